// File: rtl/count_scheduler.sv
// count_scheduler
//
// Round-robin scheduler that lends one shared up-counter to N requesters.
// A granted requester gets one clear cycle followed by L increment cycles.
// After that, the counter's final value comes back to it together with a
// one-cycle done pulse.
//
// Parameters
//   N     number of requesters (2..8)
//   W     counter width, must match the attached counter
//   LW    burst-length field width per requester
//   INIT  counter reload value, must match the attached counter
//
// Ports
//   clk     clock, all state changes on posedge
//   rst     synchronous active-high reset
//   req     per-requester request level, held until that requester's done
//   len     packed burst lengths, requester k uses len[k*LW +: LW]
//   q       current counter value
//   clr     counter reload strobe
//   c_up    counter increment strobe
//   gnt     one-hot grant, zero when idle
//   busy    high whenever a burst is in progress
//   done    one-hot, one-cycle completion pulse
//   result  counter value captured at burst end, held until the next capture

module count_scheduler #(
    parameter int          N    = 4,
    parameter int          W    = 8,
    parameter int          LW   = 4,
    parameter logic [W-1:0] INIT = 8'hff
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*LW-1:0] len,
    input  logic [W-1:0]    q,
    output logic            clr,
    output logic            c_up,
    output logic [N-1:0]    gnt,
    output logic            busy,
    output logic [N-1:0]    done,
    output logic [W-1:0]    result
);

    localparam int GW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        COUNT,
        FINISH
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [GW-1:0]   g;
    logic [GW-1:0]   last_grant;
    logic [LW-1:0]   burst_len;
    logic [LW-1:0]   remaining;

    logic [GW-1:0]   winner;
    logic [GW-1:0]   cand;
    logic            found;
    logic [LW-1:0]   lens [N];

    // Unpack the per-requester length fields so the winner can index them.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            lens[k] = len[k*LW +: LW];
        end
    end

    // Round-robin search starting just after the last granted requester.
    // The last granted requester is examined last, which gives it the
    // lowest priority when it asks again right after its own done.
    always_comb begin
        winner = last_grant;
        cand   = '0;
        found  = 1'b0;
        for (int i = 1; i <= N; i++) begin
            cand = GW'((int'(last_grant) + i) % N);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. COUNT is entered with remaining = L and exits on
    // the cycle where remaining reaches 1, which gives exactly L increments.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (found) state_next = CLEAR;
            CLEAR:  state_next = (burst_len != '0) ? COUNT : FINISH;
            COUNT:  if (remaining == LW'(1)) state_next = FINISH;
            FINISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Burst bookkeeping and registered completion outputs. The pointer
    // resets to N-1, so requester 0 wins first after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            g          <= '0;
            last_grant <= GW'(N - 1);
            burst_len  <= '0;
            remaining  <= '0;
            done       <= '0;
            result     <= '0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        g          <= winner;
                        last_grant <= winner;
                        burst_len  <= lens[winner];
                    end
                end
                CLEAR: begin
                    remaining <= burst_len;
                end
                COUNT: begin
                    remaining <= remaining - LW'(1);
                end
                FINISH: begin
                    result  <= q;
                    done[g] <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Moore outputs decoded from state and the latched grant index.
    always_comb begin
        gnt = '0;
        if (state != IDLE) begin
            gnt[g] = 1'b1;
        end
    end

    assign clr  = (state == CLEAR);
    assign c_up = (state == COUNT);
    assign busy = (state != IDLE);

endmodule
